mant_mul_seq: RTL and testbench



---
 rtl/mant_mul_pkg.sv | 25 ++
 rtl/mant_mul_seq_step_add.sv | 43 ++++
 rtl/mant_mul_seq.sv | 129 ++++++++++++
 tb/tb_mant_mul_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mant_mul_pkg.sv
// Shared definitions for the sequential mantissa multiplier.
package mant_mul_pkg;

    localparam int MANT_W_DEF = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Ceiling log2, used to size the step counter.
    function automatic int clog2(input int n);
        int          r;
        int unsigned v;
        r = 0;
        v = (n > 1) ? int'(n - 1) : 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mant_mul_seq_step_add.sv
// Ripple-carry adder used for the per-step partial-product addition.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

module mul_step_add
    import mant_mul_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic [MANT_W-1:0] i_data_one,
    input  logic [MANT_W-1:0] i_data_two,
    input  logic              i_carry,
    output logic [MANT_W-1:0] o_data,
    output logic              o_carry
);

    logic [MANT_W:0] w_c;

    assign w_c[0] = i_carry;

    for (genvar g = 0; g < MANT_W; g++) begin : g_bit
        full_adder u_fa (
            .i_a (i_data_one[g]),
            .i_b (i_data_two[g]),
            .i_c (w_c[g]),
            .o_s (o_data[g]),
            .o_c (w_c[g+1])
        );
    end

    assign o_carry = w_c[MANT_W];

endmodule

// File: rtl/mant_mul_seq.sv
// Sequential radix-2 shift-and-add mantissa multiplier, one add per clock.
// Optional build macro MANT_MUL_ZERO_BYPASS_EN: a zero operand skips CALC
// and goes straight to DONE with a zero product.
module mant_mul_seq
    import mant_mul_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [MANT_W-1:0]   i_mant_a,
    input  logic [MANT_W-1:0]   i_mant_b,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [2*MANT_W-1:0] o_product,
    output logic                o_busy
);

    localparam int CNT_W = (clog2(MANT_W) < 1) ? 1 : clog2(MANT_W);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MANT_W - 1);

    mul_state_e            r_state;
    logic [MANT_W:0]       r_acc;
    logic [MANT_W-1:0]     r_prod_lo;
    logic [MANT_W-1:0]     r_a;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_valid;
    logic                  r_busy;
    logic [2*MANT_W-1:0]   r_product;

    logic [MANT_W-1:0]     w_addend;
    logic [MANT_W-1:0]     w_sum;
    logic                  w_carry;
    logic [MANT_W:0]       w_next_acc;
    logic [MANT_W-1:0]     w_next_lo;
    logic                  w_bypass;
    logic                  w_unused_acc_msb;

`ifdef MANT_MUL_ZERO_BYPASS_EN
    assign w_bypass = (i_mant_a == '0) || (i_mant_b == '0);
`else
    assign w_bypass = 1'b0;
`endif

    // Add the multiplicand only when the current multiplier LSB is set.
    assign w_addend = r_prod_lo[0] ? r_a : '0;

    mul_step_add #(
        .MANT_W (MANT_W)
    ) u_step_add (
        .i_data_one (r_acc[MANT_W-1:0]),
        .i_data_two (w_addend),
        .i_carry    (1'b0),
        .o_data     (w_sum),
        .o_carry    (w_carry)
    );

    // Carry lands in the accumulator before the right shift, so nothing is lost.
    assign {w_next_acc, w_next_lo} = {1'b0, w_carry, w_sum, r_prod_lo[MANT_W-1:1]};

    // Accumulator MSB is always zero after the shift; it only holds the carry slot.
    assign w_unused_acc_msb = r_acc[MANT_W];

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_prod_lo <= '0;
            r_a       <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_a   <= i_mant_a;
                        r_acc <= '0;
                        if (w_bypass) begin
                            r_state   <= DONE;
                            r_prod_lo <= '0;
                            r_cnt     <= '0;
                            r_product <= '0;
                            r_valid   <= 1'b1;
                        end else begin
                            r_state   <= CALC;
                            r_prod_lo <= i_mant_b;
                            r_cnt     <= CNT_LOAD;
                            r_busy    <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_acc     <= w_next_acc;
                    r_prod_lo <= w_next_lo;
                    if (r_cnt == '0) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_valid   <= 1'b1;
                        r_product <= {w_next_acc[MANT_W-1:0], w_next_lo};
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready   = (r_state == IDLE);
    assign o_valid   = r_valid;
    assign o_busy    = r_busy;
    assign o_product = r_product;

endmodule

// File: tb/tb_mant_mul_seq.sv
// Self-checking bench for mant_mul_seq (MANT_W = 24).
module tb_mant_mul_seq;

    localparam int W = 24;
`ifdef MANT_MUL_ZERO_BYPASS_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [W-1:0]  i_mant_a;
    logic [W-1:0]  i_mant_b;
    logic          o_valid;
    logic          i_ready;
    logic [2*W-1:0] o_product;
    logic          o_busy;

    mant_mul_seq #(.MANT_W(W)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_mant_a  (i_mant_a),
        .i_mant_b  (i_mant_b),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_product (o_product),
        .o_busy    (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: one operation in flight, result = a*b after a fixed latency.
    bit             m_init = 1'b0;
    bit             m_idle = 1'b1;
    bit             m_valid = 1'b0;
    int             m_left = 0;
    logic [2*W-1:0] m_prod = '0;
    int             m_acc_cnt = 0;
    int             m_ret_cnt = 0;
    int             dut_ret_cnt = 0;

    always @(posedge clk) begin
        if (!rst && o_valid && i_ready) dut_ret_cnt++;
        if (rst) begin
            m_init  = 1'b1;
            m_idle  = 1'b1;
            m_valid = 1'b0;
            m_left  = 0;
        end else if (m_init) begin
            if (m_valid) begin
                if (i_ready) begin
                    m_valid = 1'b0;
                    m_idle  = 1'b1;
                    m_ret_cnt++;
                end
            end else if (!m_idle) begin
                m_left--;
                if (m_left == 0) m_valid = 1'b1;
            end else if (i_valid) begin
                m_idle = 1'b0;
                m_prod = (2*W)'(i_mant_a) * (2*W)'(i_mant_b);
                m_acc_cnt++;
                if (ZB && (i_mant_a == '0 || i_mant_b == '0)) m_valid = 1'b1;
                else m_left = W;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_init) begin
            chk("ready", 64'(o_ready), 64'(m_idle));
            chk("valid", 64'(o_valid), 64'(m_valid));
            chk("busy", 64'(o_busy), 64'(!m_idle && !m_valid));
            if (m_valid) chk("product", 64'(o_product), 64'(m_prod));
        end
    end

    int n_issued = 0;

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int g;
        bit idle_pre;
        i_valid  = 1'b1;
        i_mant_a = a;
        i_mant_b = b;
        g = 0;
        do begin
            idle_pre = m_idle;
            @(posedge clk);
            @(negedge clk);
            g++;
        end while (!idle_pre && g < 200);
        i_valid = 1'b0;
        if (idle_pre) n_issued++;
        else chk("accept_timeout", 64'(g), 64'(0));
    endtask

    task automatic wait_valid(input int exp_lat, input string nm, output int busy_cyc);
        int e;
        e = 0;
        busy_cyc = 0;
        while (!o_valid && e < 100) begin
            if (o_busy) busy_cyc++;
            @(posedge clk);
            @(negedge clk);
            e++;
        end
        chk({nm, "_latency"}, 64'(e), 64'(exp_lat));
    endtask

    task automatic consume();
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    int bc;
    int lat_full;
    int lat_zero;

    initial begin
        lat_full = W;
        lat_zero = ZB ? 0 : W;
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_mant_a = '0; i_mant_b = '0;
        @(posedge clk); @(negedge clk);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_product", 64'(o_product), 64'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;

        // 1: all-ones operands, full latency and busy duration
        issue(24'hFFFFFF, 24'hFFFFFF);
        wait_valid(lat_full, "t1", bc);
        chk("t1_busy_cycles", 64'(bc), 64'd24);
        chk("t1_model", 64'(m_prod), 64'h0000_FFFF_FE00_0001);
        chk("t1_product", 64'(o_product), 64'h0000_FFFF_FE00_0001);
        consume();

        // 2: two back-to-back ops; second offered during the consume cycle
        issue(24'h800000, 24'h800000);
        wait_valid(lat_full, "t2a", bc);
        chk("t2a_product", 64'(o_product), 64'h0000_4000_0000_0000);
        i_ready = 1'b1;
        issue(24'hC00000, 24'hA00000);
        chk("t2_consume_then_accept", 64'(m_ret_cnt), 64'd2);
        i_ready = 1'b0;
        wait_valid(lat_full, "t2b", bc);
        chk("t2b_model", 64'(m_prod), 64'h0000_7800_0000_0000);
        chk("t2b_product", 64'(o_product), 64'h0000_7800_0000_0000);
        consume();

        // 3: backpressure hold with ignored operands
        issue(24'h800001, 24'h800001);
        wait_valid(lat_full, "t3", bc);
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1; i_mant_a = 24'h000005; i_mant_b = 24'h000007;
            chk("t3_hold_product", 64'(o_product), 64'h0000_4000_0100_0001);
            chk("t3_hold_valid", 64'(o_valid), 64'd1);
            chk("t3_hold_ready", 64'(o_ready), 64'd0);
            @(posedge clk); @(negedge clk);
        end
        i_valid = 1'b0;
        consume();

        // 4: reset in the middle of CALC, then a small op
        issue(24'hABCDEF, 24'h123456);
        repeat (12) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("t4_rst_ready", 64'(o_ready), 64'd1);
        chk("t4_rst_valid", 64'(o_valid), 64'd0);
        chk("t4_rst_busy", 64'(o_busy), 64'd0);
        chk("t4_rst_product", 64'(o_product), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); @(negedge clk);
            chk("t4_no_valid", 64'(o_valid), 64'd0);
        end
        issue(24'h000003, 24'h000005);
        wait_valid(lat_full, "t4", bc);
        chk("t4_product", 64'(o_product), 64'h0000_0000_0000_000F);
        consume();

        // 5: zero operand
        issue(24'h000000, 24'hFFFFFF);
        wait_valid(lat_zero, "t5", bc);
        chk("t5_product", 64'(o_product), 64'd0);
        consume();

        // 6: random operands with random valid/ready gaps
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] a, b;
            int sel, g, ret0;
            sel = $urandom_range(0, 19);
            a = W'($urandom);
            b = W'($urandom);
            if (sel == 0) a = '0;
            else if (sel == 1) b = '0;
            else if (sel == 2) begin a = '1; b = '1; end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); @(negedge clk); end
            issue(a, b);
            ret0 = m_ret_cnt;
            g = 0;
            while (m_ret_cnt == ret0 && g < 300) begin
                i_ready  = 1'($urandom_range(0, 1));
                i_valid  = 1'($urandom_range(0, 1));
                i_mant_a = W'($urandom);
                i_mant_b = W'($urandom);
                @(posedge clk); @(negedge clk);
                g++;
            end
            i_ready = 1'b0;
            i_valid = 1'b0;
            if (g >= 300) chk("t6_retire_timeout", 64'(g), 64'd0);
        end

        // Every accepted op except the aborted one retires exactly once.
        chk("accepted_count", 64'(m_acc_cnt), 64'(n_issued));
        chk("retired_count", 64'(dut_ret_cnt), 64'(n_issued - 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
